lcd_timing_gen: RTL and testbench
=================================

# lcd_timing_gen

Parametrised RGB-LCD timing generator, the next generation of the fixed 480x272 driver. Produces dclk, hsync, vsync and de with independent front-porch/sync/back-porch settings and programmable polarities. Issues a per-pixel request to an external pixel source with a fixed, parametrised return latency. Supports a start/stop enable that always completes the current frame before stopping. Sits between the top-level pixel/pattern sources and the LCD pins.

## Interface
- CLK_DIV, 5: clk cycles per dclk half-period; legal range ≥3.
- PIPE_LAT, 2: clk cycles from req to pixel_in valid; legal range 0..CLK_DIV-2.
- H_ACTIVE, 480; H_FP, 2; H_SYNC, 4; H_BP, 39: horizontal timing in dclk periods. H_TOTAL = sum, ≤2047.
- V_ACTIVE, 272; V_FP, 2; V_SYNC, 4; V_BP, 12: vertical timing in lines. V_TOTAL = sum, ≤1023.
- HS_POL, 0; VS_POL, 0; DE_POL, 1: active level of hsync, vsync and de.
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assertion, active-low.
- en  in  1  run request, level-sensitive.
- pixel_in  in  24  {r,g,b} returned by the pixel source.
- req  out  1  one-clk pixel request strobe.
- pos_x  out  11  requested column (0-based, active area).
- pos_y  out  10  requested row (0-based, active area).
- red / green / blue  out  8 each  registered pixel data to the LCD.
- dclk, hsync, vsync, de  out  1 each  LCD timing signals.
- frame_start  out  1  one-clk pulse at load of position (0,0).
- busy  out  1  high when state ≠ IDLE.

## Operation
- Counters: h in 0..H_TOTAL-1, v in 0..V_TOTAL-1.
- Region order per axis: sync [0,SYNC), back porch [SYNC,SYNC+BP), active [SYNC+BP,SYNC+BP+ACTIVE), front porch (remainder).
- Outputs are driven from the counters as follows:
  - hsync = HS_POL while h is in the sync region, else ~HS_POL. vsync is the same with v and VS_POL.
  - de = DE_POL when both h and v are in the active region, else ~DE_POL.
  - pos_x = h-(H_SYNC+H_BP) and pos_y = v-(V_SYNC+V_BP) when active, else 0.
- States:
  - IDLE: dclk=0, counters 0, sync/de inactive, no req. Goes to RUN when en=1.
  - RUN: free-running. Goes to STOP when en=0.
  - STOP: keeps running. Goes back to RUN if en=1. Goes to IDLE at the falling-edge event where (h,v)=(H_TOTAL-1,V_TOTAL-1).
  - IDLE is entered with all registers at their reset values. A frame is never truncated.
- Load event L: either the IDLE→RUN transition, which loads position (0,0), or a falling-edge event in RUN/STOP, which advances h (wrap to 0 increments v; v wraps to 0).
- At the L edge, the following all update together: counters, hsync, vsync, de, frame_start.
- Wrap arithmetic is exact at H_TOTAL-1 and V_TOTAL-1. There is no overflow path.
- req is high for one clk in the cycle after L, for every position including blanking. pos_x and pos_y are held from L until the next L.
- pixel_in is sampled at edge L+1+PIPE_LAT into red/green/blue. If the position is not active, 0 is loaded instead; an active flag is delayed alongside for this purpose.
- Reset is asynchronous at any time. All state returns to reset values immediately, with no frame completion.

## Timing
- Reset values: dclk=0, hsync=~HS_POL, vsync=~VS_POL, de=~DE_POL, rgb=0, req=0, pos=0, frame_start=0, busy=0, state IDLE.
- The divider counter clears at L.
- dclk rises at edge L+CLK_DIV and falls at edge L+2·CLK_DIV. The falling edge is the next L.
- dclk period = 2·CLK_DIV clk cycles.
- rgb is stable from L+1+PIPE_LAT, which is ≥1 clk before the dclk rising edge the LCD samples on.
- First frame after start: frame_start and req both go high; timing signals for (0,0) are valid from L. The first dclk rise is CLK_DIV cycles after en is sampled high.
- Frame length = H_TOTAL·V_TOTAL·2·CLK_DIV clk cycles.

## Test plan
- Small config (CLK_DIV=3, PIPE_LAT=1, H 8/1/2/1, V 4/1/1/1): en=1 → dclk period 6; hsync low for 2 dclk per line, vsync low for 1 line; de high for 8×4 dclk per frame; frame_start every 12·7·6=504 clk.
- pixel_in = {pos_y,pos_x} modelled with 1-cycle delay → at every dclk rise while de is active, rgb equals the current coordinates; rgb=0 in blanking.
- Polarity sweep HS_POL=1, VS_POL=1, DE_POL=0 → all three signals are inverted relative to the default run; timing is identical.
- Drop en mid-frame at (h=3,v=2) → frame completes, last req at (11,6), then IDLE with busy=0 and dclk=0. Re-raise en during STOP → no gap; frame_start occurs on schedule.
- rst_n pulsed low mid-line → all outputs reach reset values asynchronously. After release with en=1, the first frame_start is at position (0,0).
- PIPE_LAT=CLK_DIV-2 boundary → rgb updates exactly 1 clk before the dclk rise, with no sample mismatch.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB-LCD timing generator: dclk/hsync/vsync/de from h/v counters,
// per-position pixel request with fixed return latency, frame-completing stop.
module lcd_timing_gen #(
  parameter int CLK_DIV  = 5,
  parameter int PIPE_LAT = 2,
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 39,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter bit DE_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] pixel_in,
  output logic        req,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        dclk,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DIV_W   = $clog2(2 * CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_FALL = DIV_W'(2 * CLK_DIV - 1);

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_LO   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_HI   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0]  V_ACT_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_ACT_HI   = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div;
  logic [10:0]         h, h_nxt;
  logic [9:0]          v, v_nxt;
  logic                fall_evt, start_evt, to_idle, l_evt, act_nxt;
  logic [PIPE_LAT:0]   vld_p;
  logic [PIPE_LAT:0]   act_p;
  logic [23:0]         rgb_p;

  function automatic logic h_is_active(input logic [10:0] x);
    return (x >= H_ACT_LO) && (x < H_ACT_HI);
  endfunction

  function automatic logic v_is_active(input logic [9:0] y);
    return (y >= V_ACT_LO) && (y < V_ACT_HI);
  endfunction

  assign fall_evt = (state != IDLE) && (div == DIV_FALL);
  assign l_evt    = start_evt | (fall_evt & ~to_idle);
  assign act_nxt  = h_is_active(h_nxt) && v_is_active(v_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_evt = 1'b0;
    to_idle   = 1'b0;
    case (state)
      IDLE: if (en) begin
        state_nxt = RUN;
        start_evt = 1'b1;
      end
      RUN:  if (!en) state_nxt = STOP;
      STOP: if (en) begin
        state_nxt = RUN;
      end else if (fall_evt && (h == H_LAST) && (v == V_LAST)) begin
        state_nxt = IDLE;
        to_idle   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position loaded at the next L: (0,0) on start, otherwise raster advance
  always_comb begin
    h_nxt = h + 11'd1;
    v_nxt = v;
    if (start_evt) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v == V_LAST) ? '0 : v + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      dclk        <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= ~DE_POL;
      pos_x       <= '0;
      pos_y       <= '0;
      frame_start <= 1'b0;
      vld_p       <= '0;
      act_p       <= '0;
      rgb_p       <= '0;
    end else if (to_idle) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      dclk        <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= ~DE_POL;
      pos_x       <= '0;
      pos_y       <= '0;
      frame_start <= 1'b0;
      vld_p       <= '0;
      act_p       <= '0;
      rgb_p       <= '0;
    end else begin
      frame_start <= 1'b0;
      // p0 is the request cycle; the pixel returns PIPE_LAT stages later
      vld_p[0] <= l_evt;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        act_p[i] <= act_p[i-1];
      end
      if (vld_p[PIPE_LAT]) rgb_p <= act_p[PIPE_LAT] ? pixel_in : '0;
      if (state != IDLE) begin
        div <= div + DIV_W'(1);
        if (div == DIV_RISE) dclk <= 1'b1;
      end
      if (l_evt) begin
        div         <= '0;
        dclk        <= 1'b0;
        h           <= h_nxt;
        v           <= v_nxt;
        hsync       <= (h_nxt < H_SYNC_END) ? HS_POL : ~HS_POL;
        vsync       <= (v_nxt < V_SYNC_END) ? VS_POL : ~VS_POL;
        de          <= act_nxt ? DE_POL : ~DE_POL;
        pos_x       <= act_nxt ? h_nxt - H_ACT_LO : '0;
        pos_y       <= act_nxt ? v_nxt - V_ACT_LO : '0;
        frame_start <= (h_nxt == '0) && (v_nxt == '0);
        act_p[0]    <= act_nxt;
      end
    end
  end

  assign req   = vld_p[0];
  assign red   = rgb_p[23:16];
  assign green = rgb_p[15:8];
  assign blue  = rgb_p[7:0];
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: default-polarity and inverted-polarity instances on a
// small raster, compared every cycle against an arithmetic frame-time model.
`timescale 1ns/1ps
module tb_lcd_timing_gen;

  localparam int CD = 3;
  localparam int HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PER = 2 * CD;
  localparam int FRAME_CLK = HT * VT * PER;

  typedef struct packed {
    logic        dclk, hs, vs, de, req, fs, busy;
    logic [10:0] x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } obs_t;

  localparam obs_t RST0 = {7'b0110000, 45'd0};
  localparam obs_t RST1 = {7'b0001000, 45'd0};

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [23:0] pix0, pix1;
  logic        req0, dclk0, hsync0, vsync0, de0, fs0, busy0;
  logic        req1, dclk1, hsync1, vsync1, de1, fs1, busy1;
  logic [10:0] pos_x0, pos_x1;
  logic [9:0]  pos_y0, pos_y1;
  logic [7:0]  red0, green0, blue0, red1, green1, blue1;
  obs_t        obs0, obs1;
  int          checks = 0, errors = 0;
  bit          m_run, m_stop;
  int          m_n;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .CLK_DIV(CD), .PIPE_LAT(1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_in(pix0), .req(req0),
    .pos_x(pos_x0), .pos_y(pos_y0), .red(red0), .green(green0), .blue(blue0),
    .dclk(dclk0), .hsync(hsync0), .vsync(vsync0), .de(de0),
    .frame_start(fs0), .busy(busy0)
  );

  lcd_timing_gen #(
    .CLK_DIV(CD), .PIPE_LAT(0),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .DE_POL(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_in(pix1), .req(req1),
    .pos_x(pos_x1), .pos_y(pos_y1), .red(red1), .green(green1), .blue(blue1),
    .dclk(dclk1), .hsync(hsync1), .vsync(vsync1), .de(de1),
    .frame_start(fs1), .busy(busy1)
  );

  // Pixel sources: one clk of latency for u0, combinational for u1
  always @(posedge clk) pix0 <= {3'b000, pos_y0, pos_x0};
  assign pix1 = {3'b000, pos_y1, pos_x1};

  assign obs0 = {dclk0, hsync0, vsync0, de0, req0, fs0, busy0, pos_x0, pos_y0, red0, green0, blue0};
  assign obs1 = {dclk1, hsync1, vsync1, de1, req1, fs1, busy1, pos_x1, pos_y1, red1, green1, blue1};

  // Run tracker: m_n counts clk edges since the start edge of the current run
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_n <= 0; m_stop <= 1'b0;
    end else if (!m_run) begin
      if (en) begin m_run <= 1'b1; m_n <= 0; m_stop <= 1'b0; end
    end else if (m_stop && !en && ((m_n + 1) % FRAME_CLK == 0)) begin
      m_run <= 1'b0; m_n <= 0; m_stop <= 1'b0;
    end else begin
      m_n <= m_n + 1; m_stop <= !en;
    end
  end

  function automatic bit in_act(input int h, input int v);
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  function automatic logic [23:0] pix_of(input int p);
    int ph, pv;
    ph = p % HT;
    pv = (p / HT) % VT;
    if (p < 0 || !in_act(ph, pv)) return 24'd0;
    return {3'b000, 10'(pv - VS - VB), 11'(ph - HS - HB)};
  endfunction

  function automatic obs_t model(input bit run, input int n, input int pl,
                                 input bit hp, input bit vp, input bit dp);
    obs_t e;
    int p, k, h, v;
    e = '0;
    e.hs = ~hp; e.vs = ~vp; e.de = ~dp;
    if (!run) return e;
    p = n / PER; k = n % PER;
    h = p % HT;  v = (p / HT) % VT;
    e.busy = 1'b1;
    e.dclk = (k >= CD);
    e.req  = (k == 0);
    e.fs   = (k == 0) && (p % (HT * VT) == 0);
    e.hs   = (h < HS) ? hp : ~hp;
    e.vs   = (v < VS) ? vp : ~vp;
    if (in_act(h, v)) begin
      e.de = dp; e.x = 11'(h - HS - HB); e.y = 10'(v - VS - VB);
    end
    e.rgb = pix_of((k >= 1 + pl) ? p : p - 1);
    return e;
  endfunction

  task automatic do_reset();
    en = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 2;
    if (obs0 !== RST0) begin errors++; $display("FAIL reset0 obs=%h exp=%h", obs0, RST0); end
    if (obs1 !== RST1) begin errors++; $display("FAIL reset1 obs=%h exp=%h", obs1, RST1); end
    en = 1'b1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (obs0 !== RST0) begin errors++; $display("FAIL reset_en0 obs=%h exp=%h", obs0, RST0); end
    if (obs1 !== RST1) begin errors++; $display("FAIL reset_en1 obs=%h exp=%h", obs1, RST1); end
  endtask

  task automatic test_timing();
    int hs_lo = 0, vs_lo = 0, de_hi = 0, rises = 0, first_rise = -1, fs_cnt = 0;
    int hs1_hi = 0, vs1_hi = 0, de1_lo = 0, p;
    logic prev_dclk = 1'b0;
    logic [23:0] exp_rgb;
    obs_t e0, e1;
    do_reset();
    en = 1'b1;
    for (int t = 0; t <= FRAME_CLK; t++) begin
      @(negedge clk);
      e0 = model(m_run, m_n, 1, 1'b0, 1'b0, 1'b1);
      e1 = model(m_run, m_n, 0, 1'b1, 1'b1, 1'b0);
      checks += 2;
      if (obs0 !== e0) begin errors++; $display("FAIL timing0 t=%0d obs=%h exp=%h", t, obs0, e0); end
      if (obs1 !== e1) begin errors++; $display("FAIL timing1 t=%0d obs=%h exp=%h", t, obs1, e1); end
      if (t < FRAME_CLK) begin
        if (hsync0 === 1'b0) hs_lo++;
        if (vsync0 === 1'b0) vs_lo++;
        if (de0 === 1'b1) de_hi++;
        if (hsync1 === 1'b1) hs1_hi++;
        if (vsync1 === 1'b1) vs1_hi++;
        if (de1 === 1'b0) de1_lo++;
        if (dclk0 === 1'b1 && prev_dclk === 1'b0) begin
          rises++;
          if (first_rise < 0) first_rise = t;
        end
        if (t % PER == CD) begin
          p = t / PER;
          exp_rgb = in_act(p % HT, p / HT) ? {3'b000, 10'(p / HT - VS - VB), 11'(p % HT - HS - HB)} : 24'd0;
          checks++;
          if ({red0, green0, blue0} !== exp_rgb) begin
            errors++; $display("FAIL rgb_at_rise t=%0d obs=%h exp=%h", t, {red0, green0, blue0}, exp_rgb);
          end
        end
      end
      if (fs0 === 1'b1) fs_cnt++;
      prev_dclk = dclk0;
    end
    checks += 9;
    if (first_rise !== CD) begin errors++; $display("FAIL first_rise obs=%0d exp=%0d", first_rise, CD); end
    if (rises !== HT * VT) begin errors++; $display("FAIL dclk_rises obs=%0d exp=%0d", rises, HT * VT); end
    if (hs_lo !== VT * HS * PER) begin errors++; $display("FAIL hsync_low obs=%0d exp=%0d", hs_lo, VT * HS * PER); end
    if (vs_lo !== VS * HT * PER) begin errors++; $display("FAIL vsync_low obs=%0d exp=%0d", vs_lo, VS * HT * PER); end
    if (de_hi !== HA * VA * PER) begin errors++; $display("FAIL de_high obs=%0d exp=%0d", de_hi, HA * VA * PER); end
    if (hs1_hi !== VT * HS * PER) begin errors++; $display("FAIL hsync_inv obs=%0d exp=%0d", hs1_hi, VT * HS * PER); end
    if (vs1_hi !== VS * HT * PER) begin errors++; $display("FAIL vsync_inv obs=%0d exp=%0d", vs1_hi, VS * HT * PER); end
    if (de1_lo !== HA * VA * PER) begin errors++; $display("FAIL de_inv obs=%0d exp=%0d", de1_lo, HA * VA * PER); end
    if (fs_cnt !== 2) begin errors++; $display("FAIL frame_start_count obs=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_stop();
    int drop_t = (2 * HT + 3) * PER + 1;
    int nreq = 0, last_req = -1, idle_at = -1;
    obs_t e0, e1;
    do_reset();
    en = 1'b1;
    for (int t = 0; t <= FRAME_CLK + 20; t++) begin
      @(negedge clk);
      e0 = model(m_run, m_n, 1, 1'b0, 1'b0, 1'b1);
      e1 = model(m_run, m_n, 0, 1'b1, 1'b1, 1'b0);
      checks += 2;
      if (obs0 !== e0) begin errors++; $display("FAIL stop0 t=%0d obs=%h exp=%h", t, obs0, e0); end
      if (obs1 !== e1) begin errors++; $display("FAIL stop1 t=%0d obs=%h exp=%h", t, obs1, e1); end
      if (t > drop_t && req0 === 1'b1) begin nreq++; last_req = t; end
      if (idle_at < 0 && busy0 === 1'b0) idle_at = t;
      if (t == FRAME_CLK) begin
        checks++;
        if (dclk0 !== 1'b0) begin errors++; $display("FAIL stop_dclk obs=%b exp=0", dclk0); end
      end
      if (t == drop_t) en = 1'b0;
    end
    checks += 3;
    if (nreq !== HT * VT - (2 * HT + 4)) begin errors++; $display("FAIL stop_reqs obs=%0d exp=%0d", nreq, HT * VT - (2 * HT + 4)); end
    if (last_req !== (HT * VT - 1) * PER) begin errors++; $display("FAIL last_req obs=%0d exp=%0d", last_req, (HT * VT - 1) * PER); end
    if (idle_at !== FRAME_CLK) begin errors++; $display("FAIL idle_at obs=%0d exp=%0d", idle_at, FRAME_CLK); end
  endtask

  task automatic test_restart();
    int drop_t = int'($urandom_range(10, 400));
    int back_t = drop_t + int'($urandom_range(1, 90));
    int gaps = 0;
    obs_t e0, e1;
    do_reset();
    en = 1'b1;
    for (int t = 0; t <= FRAME_CLK + PER; t++) begin
      @(negedge clk);
      e0 = model(m_run, m_n, 1, 1'b0, 1'b0, 1'b1);
      e1 = model(m_run, m_n, 0, 1'b1, 1'b1, 1'b0);
      checks += 2;
      if (obs0 !== e0) begin errors++; $display("FAIL restart0 t=%0d obs=%h exp=%h", t, obs0, e0); end
      if (obs1 !== e1) begin errors++; $display("FAIL restart1 t=%0d obs=%h exp=%h", t, obs1, e1); end
      if (busy0 !== 1'b1) gaps++;
      if (t == FRAME_CLK) begin
        checks++;
        if (fs0 !== 1'b1) begin errors++; $display("FAIL restart_fs obs=%b exp=1", fs0); end
      end
      if (t == drop_t) en = 1'b0;
      if (t == back_t) en = 1'b1;
    end
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL restart_gap obs=%0d exp=0", gaps); end
  endtask

  task automatic test_async_reset();
    obs_t e0, e1;
    do_reset();
    en = 1'b1;
    repeat (5 * PER + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (obs0 !== RST0) begin errors++; $display("FAIL async_rst0 obs=%h exp=%h", obs0, RST0); end
    if (obs1 !== RST1) begin errors++; $display("FAIL async_rst1 obs=%h exp=%h", obs1, RST1); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3 * PER; t++) begin
      @(negedge clk);
      e0 = model(m_run, m_n, 1, 1'b0, 1'b0, 1'b1);
      e1 = model(m_run, m_n, 0, 1'b1, 1'b1, 1'b0);
      checks += 2;
      if (obs0 !== e0) begin errors++; $display("FAIL after_rst0 t=%0d obs=%h exp=%h", t, obs0, e0); end
      if (obs1 !== e1) begin errors++; $display("FAIL after_rst1 t=%0d obs=%h exp=%h", t, obs1, e1); end
      if (t == 0) begin
        checks++;
        if ({fs0, req0, pos_x0, pos_y0} !== {2'b11, 21'd0}) begin
          errors++; $display("FAIL first_fs obs=%h exp=%h", {fs0, req0, pos_x0, pos_y0}, {2'b11, 21'd0});
        end
      end
    end
  endtask

  task automatic test_random();
    obs_t e0, e1;
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      e0 = model(m_run, m_n, 1, 1'b0, 1'b0, 1'b1);
      e1 = model(m_run, m_n, 0, 1'b1, 1'b1, 1'b0);
      checks += 2;
      if (obs0 !== e0) begin errors++; $display("FAIL random0 t=%0d obs=%h exp=%h", t, obs0, e0); end
      if (obs1 !== e1) begin errors++; $display("FAIL random1 t=%0d obs=%h exp=%h", t, obs1, e1); end
      if ($urandom_range(0, 149) == 0) en = ~en;
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_stop();
    test_restart();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
